i2s_pcm_transmitter: RTL and testbench

//  Consumes the 32-bit PCM sample stream produced by the audio sample-rate path and serialises it as a

---
 rtl/i2s_pcm_transmitter.sv | 223 ++++++++++++++++++++++
 tb/tb_i2s_pcm_transmitter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_pcm_transmitter.sv
// I2S master transmitter: pairs L/R PCM words into a stereo FIFO and serialises one pair per frame.
// Optional left-justified format is enabled by defining I2S_TX_LEFT_JUSTIFIED_EN (adds input fmt_lj).
module i2s_pcm_transmitter #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [31:0]                   pcm_din,
  input  logic                          pcm_din_valid,
  input  logic                          clr_status,
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  input  logic                          fmt_lj,
`endif
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow_sticky,
  output logic                          underflow_sticky
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SLOT_BITS);
  localparam int DV = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(SLOT_BITS - 1);
  localparam logic [DV-1:0] DIV_LAST = DV'(BCLK_DIV - 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [DV-1:0]           div_q, div_d;
  logic [CW-1:0]           bit_q, bit_d;
  logic                    bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic                    side_q, side_d;          // 0 = left slot in progress
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d, tx_r_q, tx_r_d, l_hold_q, l_hold_d;
  logic                    half_q, half_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [AW:0]             wr_q, wr_d, rd_q, rd_d, level_q, level_d;
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] head_s;
  logic [DATA_WIDTH-1:0]   sample_s;
  logic                    push_s, pop_s, ovf_set_s, udf_set_s, lj_s;
  logic                    unused_pcm_s;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  logic                    fmt_q, fmt_d;
`endif

  assign head_s       = mem[rd_q[AW-1:0]];
  assign unused_pcm_s = ^pcm_din[31:DATA_WIDTH];

  // Next-state logic: write pairing, bit-clock divider, slot sequencing and FIFO pointers
  always_comb begin
    state_d   = enable ? ST_RUN : ST_IDLE;
    div_d     = div_q;
    bit_d     = bit_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    side_d    = side_q;
    shreg_d   = shreg_q;
    tx_r_d    = tx_r_q;
    l_hold_d  = l_hold_q;
    half_d    = half_q;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    sample_s  = '0;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    fmt_d     = fmt_q;
    lj_s      = fmt_q;
`else
    lj_s      = 1'b0;
`endif

    if (pcm_din_valid) begin
      if (!half_q) begin
        l_hold_d = pcm_din[DATA_WIDTH-1:0];
        half_d   = 1'b1;
      end else begin
        half_d = 1'b0;
        if (level_q == LVL_FULL) begin
          ovf_set_s = 1'b1;
        end else begin
          push_s = 1'b1;
        end
      end
    end else begin
      half_d = half_q;
    end

    if (enable) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
        if (bclk_q) begin
          bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + CW'(1);
          if (bit_d == '0) begin
            side_d = ~side_q;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
            fmt_d = fmt_lj;
            lj_s  = fmt_lj;
`endif
            if (side_d) begin
              sample_s = tx_r_q;
            end else if (level_q != '0) begin
              pop_s    = 1'b1;
              sample_s = head_s[2*DATA_WIDTH-1:DATA_WIDTH];
              tx_r_d   = head_s[DATA_WIDTH-1:0];
            end else begin
              udf_set_s = 1'b1;
              sample_s  = '0;
              tx_r_d    = '0;
            end
            lrclk_d = side_d ^ lj_s;
            // Left-justified puts the MSB on k=0; I2S delays it by one bit
            if (lj_s) begin
              sdata_d = sample_s[DATA_WIDTH-1];
              shreg_d = {sample_s[DATA_WIDTH-2:0], 1'b0};
            end else begin
              sdata_d = 1'b0;
              shreg_d = sample_s;
            end
          end else begin
            sdata_d = shreg_q[DATA_WIDTH-1];
            shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          bit_d = bit_q;
        end
      end else begin
        div_d = div_q + DV'(1);
      end
    end else begin
      div_d   = '0;
      bit_d   = BIT_LAST;
      bclk_d  = 1'b0;
      lrclk_d = 1'b1;
      sdata_d = 1'b0;
      side_d  = 1'b1;
      shreg_d = '0;
      tx_r_d  = '0;
    end

    wr_d = wr_q + (AW+1)'(push_s);
    rd_d = rd_q + (AW+1)'(pop_s);
    // Dropping enable discards everything queued, including a half-received pair
    if ((state_q == ST_RUN) && !enable) begin
      wr_d   = '0;
      rd_d   = '0;
      half_d = 1'b0;
      push_s = 1'b0;
    end else begin
      half_d = half_d;
    end
    level_d = wr_d - rd_d;

    ovf_d = ovf_set_s ? 1'b1 : (clr_status ? 1'b0 : ovf_q);
    udf_d = udf_set_s ? 1'b1 : (clr_status ? 1'b0 : udf_q);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= BIT_LAST;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b1;
      sdata_q  <= 1'b0;
      side_q   <= 1'b1;
      shreg_q  <= '0;
      tx_r_q   <= '0;
      l_hold_q <= '0;
      half_q   <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      fmt_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      side_q   <= side_d;
      shreg_q  <= shreg_d;
      tx_r_q   <= tx_r_d;
      l_hold_q <= l_hold_d;
      half_q   <= half_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      fmt_q    <= fmt_d;
`endif
    end
  end

  // Pair storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_q[AW-1:0]] <= {l_hold_q, pcm_din[DATA_WIDTH-1:0]};
    end
  end

  assign i2s_bclk         = bclk_q;
  assign i2s_lrclk        = lrclk_q;
  assign i2s_sdata        = sdata_q;
  assign fifo_level       = level_q;
  assign overflow_sticky  = ovf_q;
  assign underflow_sticky = udf_q;
endmodule

// File: tb/tb_i2s_pcm_transmitter.sv
// Directed bench for i2s_pcm_transmitter (DATA_WIDTH=24, SLOT_BITS=32, BCLK_DIV=2, FIFO_DEPTH=16).
module tb_i2s_pcm_transmitter;
  logic        clk = 1'b0;
  logic        rst, enable, pcm_din_valid, clr_status;
  logic [31:0] pcm_din;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, overflow_sticky, underflow_sticky;
  logic [4:0]  fifo_level;

  int tests = 0;
  int fails = 0;

  logic [63:0] sd, lr;
  int          fc;
  logic [23:0] exp_l [17];
  logic [23:0] exp_r [17];
  localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

  i2s_pcm_transmitter #(
    .DATA_WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(2), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pcm_din(pcm_din),
    .pcm_din_valid(pcm_din_valid), .clr_status(clr_status),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .fifo_level(fifo_level), .overflow_sticky(overflow_sticky),
    .underflow_sticky(underflow_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] frame(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  task automatic push(input logic [31:0] w);
    @(negedge clk);
    pcm_din       = w;
    pcm_din_valid = 1'b1;
    @(negedge clk);
    pcm_din_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  // Shift in sdata/lrclk at each bclk fall; bit 63 holds the first fall when n==64
  task automatic capture(input int n, output logic [63:0] s, output logic [63:0] l, output int first);
    int   cyc;
    int   got;
    logic prev;
    s = '0; l = '0; first = -1; cyc = 0; got = 0; prev = i2s_bclk;
    while (got < n && cyc < n * 12 + 16) begin
      @(negedge clk);
      cyc++;
      if (prev && !i2s_bclk) begin
        s = {s[62:0], i2s_sdata};
        l = {l[62:0], i2s_lrclk};
        if (first < 0) first = cyc;
        got++;
      end
      prev = i2s_bclk;
    end
    check("capture_falls", 64'(got), 64'(n));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pcm_din = 32'h0; pcm_din_valid = 1'b0; clr_status = 1'b0;
    exp_l[0] = 24'h111111;
    exp_r[0] = 24'h222222;
    for (int i = 1; i < 17; i++) begin
      exp_l[i] = 24'hA00000 | 24'(i);
      exp_r[i] = 24'h0B0000 | 24'(i << 4);
    end

    repeat (3) @(negedge clk);
    check("rst_bclk", 64'(i2s_bclk), 64'd0);
    check("rst_lrclk", 64'(i2s_lrclk), 64'd1);
    check("rst_sdata", 64'(i2s_sdata), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(overflow_sticky), 64'd0);
    check("rst_udf", 64'(underflow_sticky), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single pair, upper input bits ignored
    push(32'hFFA5A5A5);
    push(32'h005A5A5A);
    check("t1_level_before", 64'(fifo_level), 64'd1);
    enable = 1'b1;
    capture(64, sd, lr, fc);
    check("t1_first_fall_clk", 64'(fc), 64'd4);
    check("t1_frame", sd, frame(24'hA5A5A5, 24'h5A5A5A));
    check("t1_lrclk", lr, LR_EXP);
    check("t1_level_after", 64'(fifo_level), 64'd0);
    check("t1_udf", 64'(underflow_sticky), 64'd0);

    // Empty FIFO frame
    capture(64, sd, lr, fc);
    check("t2_frame_zero", sd, 64'd0);
    check("t2_lrclk", lr, LR_EXP);
    check("t2_udf_set", 64'(underflow_sticky), 64'd1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t2_idle_bclk", 64'(i2s_bclk), 64'd0);
    check("t2_idle_lrclk", 64'(i2s_lrclk), 64'd1);
    check("t2_idle_sdata", 64'(i2s_sdata), 64'd0);
    check("t2_udf_held", 64'(underflow_sticky), 64'd1);
    pulse_clr();
    check("t2_udf_clr", 64'(underflow_sticky), 64'd0);

    // Half pair does not count
    push({8'h00, exp_l[0]});
    check("t4_half_level", 64'(fifo_level), 64'd0);
    push({8'h00, exp_r[0]});
    check("t4_pair_level", 64'(fifo_level), 64'd1);

    // Fill to full plus one extra pair
    for (int i = 1; i < 17; i++) begin
      push({8'h00, exp_l[i]});
      push({8'h00, exp_r[i]});
    end
    check("t3_level_full", 64'(fifo_level), 64'd16);
    check("t3_ovf_set", 64'(overflow_sticky), 64'd1);
    pulse_clr();
    check("t3_ovf_clr", 64'(overflow_sticky), 64'd0);

    // Push at full coinciding with the first pop
    push(32'h00333333);
    check("t6_level_half", 64'(fifo_level), 64'd16);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    pcm_din       = 32'h00444444;
    pcm_din_valid = 1'b1;
    @(negedge clk);
    pcm_din_valid = 1'b0;
    check("t6_lrclk_left", 64'(i2s_lrclk), 64'd0);
    check("t6_level_popped", 64'(fifo_level), 64'd15);
    check("t6_ovf_set", 64'(overflow_sticky), 64'd1);
    capture(63, sd, lr, fc);
    check("t3_read_l0", 64'(sd[62:39]), 64'(exp_l[0]));
    check("t3_read_r0", 64'(sd[30:7]), 64'(exp_r[0]));
    for (int i = 1; i < 16; i++) begin
      capture(64, sd, lr, fc);
      check($sformatf("t3_read_l%0d", i), 64'(sd[62:39]), 64'(exp_l[i]));
      check($sformatf("t3_read_r%0d", i), 64'(sd[30:7]), 64'(exp_r[i]));
    end
    check("t3_udf_before", 64'(underflow_sticky), 64'd0);
    capture(64, sd, lr, fc);
    check("t3_17th_absent", sd, 64'd0);
    check("t3_udf_after", 64'(underflow_sticky), 64'd1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);

    // Asynchronous reset at k=10 of the left slot
    push(32'h00FFFFFF);
    push(32'h00123456);
    push(32'h00ABCDEF);
    push(32'h00654321);
    check("t5_level_two", 64'(fifo_level), 64'd2);
    enable = 1'b1;
    capture(11, sd, lr, fc);
    check("t5_level_one", 64'(fifo_level), 64'd1);
    check("t5_sdata_k10", 64'(i2s_sdata), 64'd1);
    check("t5_lrclk_k10", 64'(i2s_lrclk), 64'd0);
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    check("t5_rst_bclk", 64'(i2s_bclk), 64'd0);
    check("t5_rst_lrclk", 64'(i2s_lrclk), 64'd1);
    check("t5_rst_sdata", 64'(i2s_sdata), 64'd0);
    check("t5_rst_level", 64'(fifo_level), 64'd0);
    check("t5_rst_udf", 64'(underflow_sticky), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push(32'h000F0F0F);
    push(32'h00C3C3C3);
    enable = 1'b1;
    capture(64, sd, lr, fc);
    check("t5_restart_first_fall", 64'(fc), 64'd4);
    check("t5_restart_frame", sd, frame(24'h0F0F0F, 24'hC3C3C3));
    check("t5_restart_lrclk", lr, LR_EXP);
    @(negedge clk);
    enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
